// File: rtl/ysyx_24120013_imem_if.sv
// Fetch bus between the core (master) and the instruction memory (slave):
// a request channel carrying the PC and a response channel carrying the word and fault flag.
interface ysyx_24120013_imem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_inst, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_inst, rsp_err
  );
endinterface

// File: rtl/ysyx_24120013_imem.sv
// Instruction memory with fixed-latency, single-outstanding fetch and a side loader port.
// Define YSYX_24120013_IMEM_PERF_EN to add the fetch_cnt handshake counter output.
module ysyx_24120013_imem #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_24120013_imem_if.slave   bus,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
`ifdef YSYX_24120013_IMEM_PERF_EN
  input  logic [31:0]           ld_data,
  output logic [31:0]           fetch_cnt
`else
  input  logic [31:0]           ld_data
`endif
);

  localparam int unsigned Words   = 2 ** DEPTH_LOG2;
  localparam logic [3:0]  CntInit = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] inst_q;
  logic        err_q;

  logic [31:0] mem [Words];

  logic [31:0]           off;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  fault;

  // Unsigned compare against BASE_ADDR keeps low addresses from wrapping into the array.
  always_comb begin
    off   = bus.req_addr - BASE_ADDR;
    idx   = off[DEPTH_LOG2+1:2];
    fault = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr < BASE_ADDR) ||
            ((off >> (DEPTH_LOG2 + 2)) != 32'd0);
  end

  // Loader ignores reset and FSM state; array contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      inst_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            // Non-blocking read returns the pre-write word on a same-edge loader hit.
            inst_q <= fault ? 32'h0 : mem[idx];
            err_q  <= fault;
            if (LATENCY == 1) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= CntInit;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_inst  = inst_q;
  assign bus.rsp_err   = err_q;

`ifdef YSYX_24120013_IMEM_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
    end else if ((state_q == StResp) && bus.rsp_ready && (fetch_cnt != 32'hFFFF_FFFF)) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_24120013_imem.sv
// Scoreboarded bench for the instruction memory: latency, faults, backpressure,
// same-edge loader hazard, reset discard and (with YSYX_24120013_IMEM_PERF_EN) the fetch counter.
module tb_ysyx_24120013_imem;

  localparam int unsigned LAT  = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;
`ifdef YSYX_24120013_IMEM_PERF_EN
  logic [31:0] fetch_cnt;
`endif

  ysyx_24120013_imem_if bus ();

  ysyx_24120013_imem #(
    .DEPTH_LOG2 (10),
    .LATENCY    (LAT),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
`ifdef YSYX_24120013_IMEM_PERF_EN
    .ld_data   (ld_data),
    .fetch_cnt (fetch_cnt)
`else
    .ld_data (ld_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [1024];
  logic [32:0] sb [$];

  function automatic logic [32:0] model(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    if (a[1:0] != 2'b00 || a < BASE || o >= 32'd4096) return {1'b1, 32'h0};
    return {1'b0, ref_mem[o[11:2]]};
  endfunction

  task automatic load(input logic [9:0] i, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = i; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    ref_mem[i] = d;
  endtask

  // hold: cycles in RESP with rsp_ready low; poke: drive req_valid during them;
  // same_ld: loader writes the fetched word on the acceptance edge.
  task automatic do_fetch(input logic [31:0] addr, input int hold, input bit poke,
                          input bit same_ld, input logic [31:0] same_data);
    logic [32:0] exp;
    logic [31:0] held;
    logic [31:0] o;
    int cyc;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL req_ready_idle addr=%h: got %b want 1", addr, bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    sb.push_back(model(addr));
    o = addr - BASE;
    if (same_ld) begin
      ld_en = 1'b1; ld_addr = o[11:2]; ld_data = same_data;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    ld_en = 1'b0;
    if (same_ld) ref_mem[o[11:2]] = same_data;
    cyc = 1;
    while (bus.rsp_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != LAT) begin
      errors++; $display("FAIL latency addr=%h: got %0d want %0d", addr, cyc, LAT);
    end
    held = bus.rsp_inst;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        bus.req_valid = 1'b1; bus.req_addr = BASE;
      end
      @(posedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_inst !== held || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d: valid=%b inst=%h ready=%b want 1 %h 0",
                 i, bus.rsp_valid, bus.rsp_inst, bus.req_ready, held);
      end
    end
    bus.req_valid = 1'b0;
    exp = sb.pop_front();
    checks++;
    if (bus.rsp_inst !== exp[31:0]) begin
      errors++; $display("FAIL rsp_inst addr=%h: got %h want %h", addr, bus.rsp_inst, exp[31:0]);
    end
    checks++;
    if (bus.rsp_err !== exp[32]) begin
      errors++; $display("FAIL rsp_err addr=%h: got %b want %b", addr, bus.rsp_err, exp[32]);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_handshake: ready=%b valid=%b want 1 0", bus.req_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 ||
        bus.rsp_inst !== 32'h0 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b inst=%h err=%b want 1 0 0 0",
               bus.req_ready, bus.rsp_valid, bus.rsp_inst, bus.rsp_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch;
    load(10'd0, 32'h0010_0093);
    load(10'd1, 32'h0000_0073);
    do_fetch(32'h8000_0004, 0, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h8000_0000, 0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_fault;
    load(10'd1023, 32'h0BAD_F00D);
    do_fetch(32'h8000_0002, 0, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h7FFF_FFFC, 0, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h8000_0FFC, 0, 1'b0, 1'b0, 32'h0);
    do_fetch(32'h8000_1000, 0, 1'b0, 1'b0, 32'h0);
    do_fetch(32'hFFFF_FFFC, 0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_backpressure;
    do_fetch(32'h8000_0004, 5, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_second_accept: ready=%b valid=%b want 1 0", bus.req_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_same_edge;
    load(10'd3, 32'h1234_5678);
    do_fetch(32'h8000_000C, 0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    do_fetch(32'h8000_000C, 0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      logic [9:0] w;
      w = 10'($urandom_range(4, 1022));
      load(w, $urandom);
      do_fetch(BASE + {20'h0, w, 2'b00}, i % 3, 1'b0, 1'b0, 32'h0);
    end
  endtask

  task automatic test_reset_inflight;
    bit seen;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h8000_0000;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    ld_en = 1'b1; ld_addr = 10'd5; ld_data = 32'h5555_AAAA;
    @(posedge clk); #1;
    rst = 1'b0;
    ld_en = 1'b0;
    ref_mem[5] = 32'h5555_AAAA;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_inst !== 32'h0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_wait: valid=%b inst=%h ready=%b want 0 0 1",
               bus.rsp_valid, bus.rsp_inst, bus.req_ready);
    end
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL discarded_rsp: rsp_valid rose got 1 want 0");
    end
    do_fetch(32'h8000_0014, 0, 1'b0, 1'b0, 32'h0);
  endtask

`ifdef YSYX_24120013_IMEM_PERF_EN
  task automatic test_perf;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) do_fetch(32'h8000_0000, i, 1'b0, 1'b0, 32'h0);
    checks++;
    if (fetch_cnt !== 32'd3) begin
      errors++; $display("FAIL fetch_cnt: got %0d want 3", fetch_cnt);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (fetch_cnt !== 32'd0) begin
      errors++; $display("FAIL fetch_cnt_reset: got %0d want 0", fetch_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.rsp_ready = 1'b0;
    test_reset();
    test_fetch();
    test_fault();
    test_backpressure();
    test_same_edge();
    test_back_to_back();
    test_reset_inflight();
`ifdef YSYX_24120013_IMEM_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
